// File: rtl/draw_tank_sprite.sv
// draw_tank_sprite: sprite-overlay stage of the VGA pixel pipeline.
// Generates the tank ROM address {row, col} for pixels inside the sprite
// footprint, overlays the returned ROM pixel with colour-key transparency and
// delays timing/counter signals so every output lags its input by 3 clocks.
// Optional feature macro: TANK_ROTATE_EN (enables the dir-driven rotation).
module draw_tank_sprite #(
    parameter int          SPRITE_W = 48,
    parameter int          SPRITE_H = 64,
    parameter logic [11:0] KEY_RGB  = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [1:0]  dir,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] pixel_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);
    localparam logic [12:0] W13  = 13'(SPRITE_W);
    localparam logic [12:0] H13  = 13'(SPRITE_H);
    localparam logic [5:0]  W_M1 = 6'(SPRITE_W - 1);
    localparam logic [5:0]  H_M1 = 6'(SPRITE_H - 1);

    // Frame-latched placement
    logic        r_vblnk_prev;
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
`ifdef TANK_ROTATE_EN
    logic [1:0]  r_dir;
`else
    // dir is intentionally ignored in this build
    logic        w_unused_dir;
    assign w_unused_dir = ^dir;
`endif

    // Capture placement only on the vblank rising edge so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_xpos       <= '0;
            r_ypos       <= '0;
`ifdef TANK_ROTATE_EN
            r_dir        <= '0;
`endif
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (vblnk_in && !r_vblnk_prev) begin
                r_xpos <= xpos;
                r_ypos <= ypos;
`ifdef TANK_ROTATE_EN
                r_dir  <= dir;
`endif
            end
        end
    end

    // Footprint test in 13 bits so a sprite near 4095 cannot wrap around.
    logic [12:0] w_h13, w_v13, w_x13, w_y13;
    logic [12:0] w_fw, w_fh;
    logic        w_in_sprite;
    // Only the low 6 bits of the offsets are ever needed for the address.
    logic [5:0]  w_rx, w_ry;
    logic [5:0]  w_col, w_row;
    logic [11:0] w_addr;

    assign w_h13 = {2'b00, hcount_in};
    assign w_v13 = {2'b00, vcount_in};
    assign w_x13 = {1'b0, r_xpos};
    assign w_y13 = {1'b0, r_ypos};
    assign w_rx  = hcount_in[5:0] - r_xpos[5:0];
    assign w_ry  = vcount_in[5:0] - r_ypos[5:0];

    // Footprint size and screen-to-ROM coordinate mapping for the heading.
    always_comb begin
        w_fw  = W13;
        w_fh  = H13;
        w_col = w_rx;
        w_row = w_ry;
`ifdef TANK_ROTATE_EN
        if (r_dir[0]) begin
            w_fw = H13;
            w_fh = W13;
        end
        case (r_dir)
            2'd1: begin
                w_col = w_ry;
                w_row = H_M1 - w_rx;
            end
            2'd2: begin
                w_col = W_M1 - w_rx;
                w_row = H_M1 - w_ry;
            end
            2'd3: begin
                w_col = W_M1 - w_ry;
                w_row = w_rx;
            end
            default: begin
                w_col = w_rx;
                w_row = w_ry;
            end
        endcase
`endif
    end

    assign w_in_sprite = (w_h13 >= w_x13) && (w_h13 < w_x13 + w_fw) &&
                         (w_v13 >= w_y13) && (w_v13 < w_y13 + w_fh);
    assign w_addr = w_in_sprite ? {w_row, w_col} : 12'h000;

    // Delay-stage registers (E1, E2)
    logic        r_in_sprite_d1, r_in_sprite_d2;
    logic [10:0] r_hcount_d1, r_hcount_d2;
    logic [10:0] r_vcount_d1, r_vcount_d2;
    logic        r_hsync_d1, r_hsync_d2;
    logic        r_vsync_d1, r_vsync_d2;
    logic        r_hblnk_d1, r_hblnk_d2;
    logic        r_vblnk_d1, r_vblnk_d2;
    logic [11:0] r_rgb_d1, r_rgb_d2;

    // Three-stage pipeline: address issue, ROM wait, composite.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr     <= '0;
            r_in_sprite_d1 <= 1'b0;
            r_hcount_d1    <= '0;
            r_vcount_d1    <= '0;
            r_hsync_d1     <= 1'b0;
            r_vsync_d1     <= 1'b0;
            r_hblnk_d1     <= 1'b0;
            r_vblnk_d1     <= 1'b0;
            r_rgb_d1       <= '0;
            r_in_sprite_d2 <= 1'b0;
            r_hcount_d2    <= '0;
            r_vcount_d2    <= '0;
            r_hsync_d2     <= 1'b0;
            r_vsync_d2     <= 1'b0;
            r_hblnk_d2     <= 1'b0;
            r_vblnk_d2     <= 1'b0;
            r_rgb_d2       <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            hsync_out      <= 1'b0;
            vsync_out      <= 1'b0;
            hblnk_out      <= 1'b0;
            vblnk_out      <= 1'b0;
            rgb_out        <= '0;
        end else begin
            // E1
            pixel_addr     <= w_addr;
            r_in_sprite_d1 <= w_in_sprite;
            r_hcount_d1    <= hcount_in;
            r_vcount_d1    <= vcount_in;
            r_hsync_d1     <= hsync_in;
            r_vsync_d1     <= vsync_in;
            r_hblnk_d1     <= hblnk_in;
            r_vblnk_d1     <= vblnk_in;
            r_rgb_d1       <= rgb_in;
            // E2: the ROM is reading pixel_addr during this stage
            r_in_sprite_d2 <= r_in_sprite_d1;
            r_hcount_d2    <= r_hcount_d1;
            r_vcount_d2    <= r_vcount_d1;
            r_hsync_d2     <= r_hsync_d1;
            r_vsync_d2     <= r_vsync_d1;
            r_hblnk_d2     <= r_hblnk_d1;
            r_vblnk_d2     <= r_vblnk_d1;
            r_rgb_d2       <= r_rgb_d1;
            // E3: blanking overrides everything, then opaque sprite pixels
            hcount_out     <= r_hcount_d2;
            vcount_out     <= r_vcount_d2;
            hsync_out      <= r_hsync_d2;
            vsync_out      <= r_vsync_d2;
            hblnk_out      <= r_hblnk_d2;
            vblnk_out      <= r_vblnk_d2;
            if (r_hblnk_d2 || r_vblnk_d2)
                rgb_out <= 12'h000;
            else if (r_in_sprite_d2 && (rgb_pixel != KEY_RGB))
                rgb_out <= rgb_pixel;
            else
                rgb_out <= r_rgb_d2;
        end
    end
endmodule

// File: tb/tb_draw_tank_sprite.sv
// Testbench for draw_tank_sprite: table vectors for addresses plus a
// scoreboard that predicts the 3-cycle-delayed output stream.
`timescale 1ns/1ps
module tb_draw_tank_sprite;
    localparam int          SW  = 48;
    localparam int          SH  = 64;
    localparam logic [11:0] KEY = 12'hF0F;
`ifdef TANK_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic [1:0]  dir;
    logic [11:0] rgb_pixel;
    logic [11:0] pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_tank_sprite dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .dir(dir),
        .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // ROM contents: every address with low nibble 5 holds the colour key.
    function automatic logic [11:0] rom_f(input logic [11:0] a);
        if (a[3:0] == 4'h5) return KEY;
        return a ^ 12'h4A2;
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rgb_pixel <= rom_f(pixel_addr);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } out_t;

    typedef struct {
        string       name;
        int          h, v;
        logic        hb;
        logic [11:0] addr;
    } vec_t;

    out_t exp_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_x = 0, m_y = 0, m_d = 0;
    bit   m_prev = 1'b0;

    // Reference footprint/address model on plain integers.
    function automatic void model_addr(input int h, input int v, input int xl,
                                       input int yl, input int d,
                                       output bit ins, output logic [11:0] a);
        int w, hh, rx, ry, col, row;
        logic [5:0] c6, r6;
        if (!ROT) d = 0;
        w  = (d % 2 == 1) ? SH : SW;
        hh = (d % 2 == 1) ? SW : SH;
        ins = (h >= xl) && (h < xl + w) && (v >= yl) && (v < yl + hh);
        rx = h - xl;
        ry = v - yl;
        case (d)
            0:       begin col = rx;          row = ry;          end
            1:       begin col = ry;          row = SH - 1 - rx; end
            2:       begin col = SW - 1 - rx; row = SH - 1 - ry; end
            default: begin col = SW - 1 - ry; row = rx;          end
        endcase
        c6 = col[5:0];
        r6 = row[5:0];
        a = ins ? {r6, c6} : 12'h000;
    endfunction

    // One pixel clock: predict, advance, compare address and delayed stream.
    task automatic step();
        out_t        e, got, want;
        bit          ins;
        logic [11:0] a, rv;
        model_addr(int'(hcount_in), int'(vcount_in), m_x, m_y, m_d, ins, a);
        if (rst) begin
            a = 12'h000;
            foreach (exp_q[k]) exp_q[k] = '0;
            e = '0;
        end else begin
            rv = rom_f(a);
            e.h = hcount_in; e.v = vcount_in;
            e.hs = hsync_in; e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
            if (hblnk_in || vblnk_in)     e.rgb = 12'h000;
            else if (ins && rv != KEY)    e.rgb = rv;
            else                          e.rgb = rgb_in;
        end
        exp_q.push_back(e);
        if (rst) begin
            m_x = 0; m_y = 0; m_d = 0; m_prev = 1'b0;
        end else begin
            if (vblnk_in && !m_prev) begin
                m_x = int'(xpos); m_y = int'(ypos); m_d = int'(dir);
            end
            m_prev = vblnk_in;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (pixel_addr !== a) begin
            n_bad++;
            $display("FAIL addr_model: got %h want %h", pixel_addr, a);
        end
        if (exp_q.size() == 3) begin
            want = exp_q.pop_front();
            got  = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL stream: got h=%0d v=%0d hs%b vs%b hb%b vb%b rgb=%h want h=%0d v=%0d hs%b vs%b hb%b vb%b rgb=%h",
                         got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.rgb,
                         want.h, want.v, want.hs, want.vs, want.hb, want.vb, want.rgb);
            end
        end
    endtask

    task automatic add(input string name, input int h, input int v,
                       input logic hb, input logic [11:0] addr);
        vec_t t;
        t.name = name; t.h = h; t.v = v; t.hb = hb; t.addr = addr;
        vecs.push_back(t);
    endtask

    // Apply the vector table; each record also checks the hand-derived address.
    task automatic run_vecs();
        foreach (vecs[k]) begin
            hcount_in = 11'(vecs[k].h);
            vcount_in = 11'(vecs[k].v);
            hblnk_in  = vecs[k].hb;
            rgb_in    = 12'($urandom);
            step();
            n_cmp++;
            if (pixel_addr !== vecs[k].addr) begin
                n_bad++;
                $display("FAIL %s: pixel_addr got %h want %h", vecs[k].name, pixel_addr, vecs[k].addr);
            end
            $display("vec %s (%0d,%0d) addr=%h", vecs[k].name, vecs[k].h, vecs[k].v, pixel_addr);
        end
        hblnk_in = 1'b0;
        vecs.delete();
    endtask

    task automatic latch_pos(input int x, input int y, input int d);
        xpos = 12'(x); ypos = 12'(y); dir = 2'(d);
        vblnk_in = 1'b1;
        step();
        vblnk_in = 1'b0;
        step();
    endtask

    initial begin
        int lat;
        bool_seen: begin end
        rst = 1'b1;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        // Reset with random inputs: outputs must all stay at 0
        for (int i = 0; i < 5; i++) begin
            hcount_in = 11'($urandom); vcount_in = 11'($urandom);
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
            rgb_in = 12'($urandom); xpos = 12'($urandom); ypos = 12'($urandom);
            dir = 2'($urandom);
            step();
        end
        n_cmp++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, pixel_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got nonzero want all 0");
        end
        rst = 1'b0;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        hcount_in = 0; vcount_in = 0;
        step(); step(); step();

        // hsync pulse latency
        hsync_in = 1'b1;
        step();
        hsync_in = 1'b0;
        lat = 1;
        while (hsync_out !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL hsync_latency: got %0d want 3", lat);
        end
        $display("hsync latency %0d", lat);

        // Placement dir 0 and transparency
        latch_pos(100, 50, 0);
        add("origin",   100,  50, 1'b0, 12'h000);
        add("far",      147, 113, 1'b0, 12'hFEF);
        add("right_out",148,  50, 1'b0, 12'h000);
        add("left_out",  99,  50, 1'b0, 12'h000);
        add("top_out",  100,  49, 1'b0, 12'h000);
        add("tr",       147,  50, 1'b0, 12'h02F);
        add("bl",       100, 113, 1'b0, 12'hFC0);
        add("bot_out",  100, 114, 1'b0, 12'h000);
        add("mid",      110,  60, 1'b0, 12'h28A);
        add("key",      105,  50, 1'b0, 12'h005);
        add("blank_in", 120,  70, 1'b1, 12'h514);
        run_vecs();

        // Mid-frame xpos change must not move the sprite
        xpos = 12'd200;
        add("stay_old", 101, 51, 1'b0, 12'h041);
        add("no_new",   201, 51, 1'b0, 12'h000);
        run_vecs();
        latch_pos(200, 50, 0);
        add("moved_new", 201, 51, 1'b0, 12'h041);
        add("moved_old", 101, 51, 1'b0, 12'h000);
        run_vecs();
        // Held vblank: only its rising edge captures
        vblnk_in = 1'b1; step();
        xpos = 12'd300; step();
        vblnk_in = 1'b0; step();
        add("held_vb", 201, 51, 1'b0, 12'h041);
        run_vecs();

        // Rotation / ignored dir
        latch_pos(0, 0, 1);
`ifdef TANK_ROTATE_EN
        add("rot_00",    0,  0, 1'b0, 12'hFC0);
        add("rot_far",  63, 47, 1'b0, 12'h02F);
        add("rot_xout", 64,  0, 1'b0, 12'h000);
        add("rot_yout",  0, 48, 1'b0, 12'h000);
`else
        add("nrot_00",   0,  0, 1'b0, 12'h000);
        add("nrot_far", 47, 63, 1'b0, 12'hFEF);
        add("nrot_xout",48,  0, 1'b0, 12'h000);
        add("nrot_yin",  0, 48, 1'b0, 12'hC00);
`endif
        run_vecs();

        // Right-edge clip, no wrap near x=0
        latch_pos(780, 0, 0);
        add("clip_first", 780, 0, 1'b0, 12'h000);
        add("clip_last",  799, 0, 1'b0, 12'h013);
        add("clip_left",  779, 0, 1'b0, 12'h000);
        add("nowrap0",      0, 0, 1'b0, 12'h000);
        add("nowrap19",    19, 0, 1'b0, 12'h000);
        run_vecs();

        // vblank edge coinciding with reset: reset wins
        rst = 1'b1; vblnk_in = 1'b1; xpos = 12'd500; ypos = 12'd0;
        step();
        rst = 1'b0; vblnk_in = 1'b0;
        step();
        add("rst_win_new", 501, 1, 1'b0, 12'h000);
        add("rst_win_zero",  1, 1, 1'b0, 12'h041);
        run_vecs();

        // Random stream around a moving sprite
        for (int i = 0; i < 300; i++) begin
            hcount_in = 11'($urandom_range(160, 80));
            vcount_in = 11'($urandom_range(130, 30));
            hsync_in  = 1'($urandom);
            vsync_in  = 1'($urandom);
            hblnk_in  = ($urandom_range(7, 0) == 0);
            vblnk_in  = ($urandom_range(15, 0) == 0);
            rgb_in    = 12'($urandom);
            if ($urandom_range(7, 0) == 0) begin
                xpos = 12'($urandom_range(110, 90));
                ypos = 12'($urandom_range(60, 40));
                dir  = 2'($urandom);
            end
            step();
        end
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end
endmodule
